// File: rtl/trade_mean_fsm.sv
// trade_mean_fsm
// Stateful mean-reversion strategy unit. Sits between the SMA stage and the
// TLU. On every valid sample it compares the current price against a band of
// +/- threshold around the midpoint of the short/long SMAs. It tracks a
// position (FLAT/LONG/SHORT/COOLDOWN) and emits one-cycle entry/exit pulses.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   data_valid_pre    - sample qualifier from the SMA stage
//   short_sma         - short moving average
//   long_sma          - long moving average
//   current_data      - current price
//   threshold         - band half-width, used with each valid sample
//   flush             - synchronous force-to-FLAT
//   buy_signal        - registered buy pulse
//   sell_signal       - registered sell pulse
//   timeout_exit      - high with an exit pulse forced by MAX_HOLD
//   data_valid_mean   - registered copy of data_valid_pre
//   position          - 00 FLAT, 01 LONG, 10 SHORT, 11 COOLDOWN
module trade_mean_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 16,
    parameter int COOLDOWN   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid_pre,
    input  logic [DATA_WIDTH-1:0] short_sma,
    input  logic [DATA_WIDTH-1:0] long_sma,
    input  logic [DATA_WIDTH-1:0] current_data,
    input  logic [DATA_WIDTH-1:0] threshold,
    input  logic                  flush,
    output logic                  buy_signal,
    output logic                  sell_signal,
    output logic                  timeout_exit,
    output logic                  data_valid_mean,
    output logic [1:0]            position
);

    localparam int HOLD_W_RAW = $clog2(MAX_HOLD + 1);
    localparam int CNT_W_RAW  = $clog2(COOLDOWN + 1);
    localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;
    localparam int CNT_W      = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]  COOL_C     = CNT_W'(COOLDOWN);

    typedef enum logic [1:0] {
        ST_FLAT  = 2'b00,
        ST_LONG  = 2'b01,
        ST_SHORT = 2'b10,
        ST_COOL  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                buy_q, buy_d;
    logic                sell_q, sell_d;
    logic                timeout_q, timeout_d;
    logic                dv_q, dv_d;

    // Band arithmetic: sum carries one extra bit so the midpoint never wraps;
    // the upper bound saturates instead of wrapping.
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] mid;
    logic [DATA_WIDTH:0]   upper_full;
    logic [DATA_WIDTH-1:0] upper;
    logic [DATA_WIDTH-1:0] lower;
    logic                  trend;
    logic [HOLD_W-1:0]     hold_n;
    logic [CNT_W-1:0]      cnt_n;
    state_t                exit_state;

    always_comb begin
        sum        = {1'b0, short_sma} + {1'b0, long_sma};
        mid        = DATA_WIDTH'(sum >> 1);
        upper_full = {1'b0, mid} + {1'b0, threshold};
        upper      = upper_full[DATA_WIDTH] ? '1 : upper_full[DATA_WIDTH-1:0];
        lower      = (mid > threshold) ? (mid - threshold) : '0;
        trend      = short_sma > long_sma;
        hold_n     = hold_q + 1'b1;
        cnt_n      = cnt_q + 1'b1;
        exit_state = (COOLDOWN > 0) ? ST_COOL : ST_FLAT;
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        buy_d     = 1'b0;
        sell_d    = 1'b0;
        timeout_d = 1'b0;
        dv_d      = data_valid_pre;

        if (flush) begin
            state_d = ST_FLAT;
            hold_d  = '0;
            cnt_d   = '0;
        end else if (data_valid_pre) begin
            case (state_q)
                ST_FLAT: begin
                    if (trend && (current_data < lower)) begin
                        buy_d   = 1'b1;
                        state_d = ST_LONG;
                        hold_d  = '0;
                    end else if (!trend && (current_data > upper)) begin
                        sell_d  = 1'b1;
                        state_d = ST_SHORT;
                        hold_d  = '0;
                    end
                end
                ST_LONG: begin
                    // Revert wins over timeout: timeout_exit only flags exits
                    // that the band alone would not have produced.
                    if (current_data >= mid) begin
                        sell_d  = 1'b1;
                        state_d = exit_state;
                        hold_d  = '0;
                        cnt_d   = '0;
                    end else if (hold_n == MAX_HOLD_C) begin
                        sell_d    = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = exit_state;
                        hold_d    = '0;
                        cnt_d     = '0;
                    end else begin
                        hold_d = hold_n;
                    end
                end
                ST_SHORT: begin
                    if (current_data <= mid) begin
                        buy_d   = 1'b1;
                        state_d = exit_state;
                        hold_d  = '0;
                        cnt_d   = '0;
                    end else if (hold_n == MAX_HOLD_C) begin
                        buy_d     = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = exit_state;
                        hold_d    = '0;
                        cnt_d     = '0;
                    end else begin
                        hold_d = hold_n;
                    end
                end
                ST_COOL: begin
                    if (cnt_n == COOL_C) begin
                        state_d = ST_FLAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_n;
                    end
                end
                default: begin
                    state_d = ST_FLAT;
                    hold_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FLAT;
            hold_q    <= '0;
            cnt_q     <= '0;
            buy_q     <= 1'b0;
            sell_q    <= 1'b0;
            timeout_q <= 1'b0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            buy_q     <= buy_d;
            sell_q    <= sell_d;
            timeout_q <= timeout_d;
            dv_q      <= dv_d;
        end
    end

    assign buy_signal      = buy_q;
    assign sell_signal     = sell_q;
    assign timeout_exit    = timeout_q;
    assign data_valid_mean = dv_q;
    assign position        = state_q;

endmodule

// File: tb/tb_trade_mean_fsm.sv
// Self-checking bench for trade_mean_fsm (DATA_WIDTH=8, MAX_HOLD=4, COOLDOWN=2).
module tb_trade_mean_fsm;

    logic       clk;
    logic       rst;
    logic       data_valid_pre;
    logic [7:0] short_sma;
    logic [7:0] long_sma;
    logic [7:0] current_data;
    logic [7:0] threshold;
    logic       flush;
    logic       buy_signal;
    logic       sell_signal;
    logic       timeout_exit;
    logic       data_valid_mean;
    logic [1:0] position;

    int unsigned n_cmp;
    int unsigned n_bad;

    trade_mean_fsm #(
        .DATA_WIDTH(8),
        .MAX_HOLD  (4),
        .COOLDOWN  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_valid_pre (data_valid_pre),
        .short_sma      (short_sma),
        .long_sma       (long_sma),
        .current_data   (current_data),
        .threshold      (threshold),
        .flush          (flush),
        .buy_signal     (buy_signal),
        .sell_signal    (sell_signal),
        .timeout_exit   (timeout_exit),
        .data_valid_mean(data_valid_mean),
        .position       (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected output word: {buy, sell, timeout, dv_mean, position[1:0]}
    typedef struct {
        logic       v;
        logic [7:0] s;
        logic [7:0] l;
        logic [7:0] c;
        logic [7:0] t;
        logic       f;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] sb_q[$];
    string      sb_name[$];

    function automatic logic [5:0] outs();
        return {buy_signal, sell_signal, timeout_exit, data_valid_mean, position};
    endfunction

    task automatic add(input logic v, input int s, input int l, input int c,
                       input int t, input logic f, input logic [5:0] exp,
                       input string name);
        vec_t x;
        x.v = v; x.s = 8'(s); x.l = 8'(l); x.c = 8'(c); x.t = 8'(t);
        x.f = f; x.exp = exp; x.name = name;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got b/s/to/dv/pos=%b required %b", name, act, exp);
        end
    endtask

    // Drive one sample, push its expectation, then pop and compare after the edge.
    task automatic step(input vec_t x);
        data_valid_pre = x.v;
        short_sma      = x.s;
        long_sma       = x.l;
        current_data   = x.c;
        threshold      = x.t;
        flush          = x.f;
        sb_q.push_back(x.exp);
        sb_name.push_back(x.name);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got empty queue required one entry");
        end else begin
            check(sb_name.pop_front(), outs(), sb_q.pop_front());
        end
        flush = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; data_valid_pre = 1'b0; flush = 1'b0;
        short_sma = '0; long_sma = '0; current_data = '0; threshold = '0;

        // buy_signal, sell_signal, timeout, dv, pos
        // cooldown walk with entry/exit (thr=5, mid=105, lower=100)
        add(1,110,100, 99,5,0,6'b100101,"entry_long");
        add(1,110,100,106,5,0,6'b010111,"revert_long_exit");
        add(1,110,100, 90,5,0,6'b000111,"cool_1");
        add(1,110,100, 90,5,0,6'b000100,"cool_2_to_flat");
        add(1,110,100, 90,5,0,6'b100101,"entry_after_cool");
        add(1,110,100,106,5,0,6'b010111,"exit2");
        add(1,110,100, 90,5,0,6'b000111,"cool2_1");
        add(1,110,100, 90,5,0,6'b000100,"cool2_2");
        add(0,110,100, 90,5,0,6'b000000,"idle");
        // short entry and MAX_HOLD timeout (mid=105, upper=110)
        add(1,100,110,115,5,0,6'b010110,"entry_short");
        add(1,100,110,112,5,0,6'b000110,"hold_1");
        add(1,100,110,112,5,0,6'b000110,"hold_2");
        add(1,100,110,112,5,0,6'b000110,"hold_3");
        add(1,100,110,112,5,0,6'b101111,"timeout_short");
        add(1,100,110,112,5,0,6'b000111,"cool3_1");
        add(1,100,110,112,5,0,6'b000100,"cool3_2");
        // upper saturation: mid=245, thr=20 -> upper 255
        add(1,240,250,255,20,0,6'b000100,"sat_no_sell");
        add(1,240,250,254, 8,0,6'b010110,"thr8_sell");
        add(1,240,250,245, 8,0,6'b100111,"revert_at_mid");
        add(1,240,250,245, 8,0,6'b000111,"cool4_1");
        add(1,240,250,245, 8,0,6'b000100,"cool4_2");
        // revert and timeout on the same sample
        add(1,100,110,115,5,0,6'b010110,"entry_short2");
        add(1,100,110,112,5,0,6'b000110,"hold2_1");
        add(1,100,110,112,5,0,6'b000110,"hold2_2");
        add(1,100,110,112,5,0,6'b000110,"hold2_3");
        add(1,100,110,100,5,0,6'b100111,"revert_beats_timeout");
        add(1,100,110,100,5,0,6'b000111,"cool5_1");
        add(1,100,110,100,5,0,6'b000100,"cool5_2");
        // lower clamps to 0 when mid <= thr (mid=7, thr=10)
        add(1, 10,  4,  0,10,0,6'b000100,"lower_clamp");
        // valid gaps hold everything
        for (int i = 0; i < 5; i++)
            add(0,110,100, 99,5,0,6'b000000,"gap_flat");
        add(1,110,100, 99,5,0,6'b100101,"entry_after_gap");
        add(0,110,100,100,5,0,6'b000001,"gap_long_1");
        add(0,110,100,100,5,0,6'b000001,"gap_long_2");
        add(1,110,100,100,5,0,6'b000101,"long_hold_1");
        add(1,110,100,100,5,0,6'b000101,"long_hold_2");
        add(1,110,100,100,5,0,6'b000101,"long_hold_3");
        add(1,110,100,100,5,0,6'b011111,"timeout_long");
        add(1,110,100,100,5,0,6'b000111,"cool6_1");
        add(1,110,100,100,5,0,6'b000100,"cool6_2");
        // flush while SHORT, hold=2, with a revert sample
        add(1,100,110,115,5,0,6'b010110,"entry_short3");
        add(1,100,110,112,5,0,6'b000110,"hold3_1");
        add(1,100,110,112,5,0,6'b000110,"hold3_2");
        add(1,100,110,100,5,1,6'b000100,"flush_over_revert");
        add(1,100,110,115,5,0,6'b010110,"entry_after_flush");
        add(1,100,110,112,5,0,6'b000110,"hold4_1");
        add(1,100,110,112,5,0,6'b000110,"hold4_2");
        add(1,100,110,112,5,0,6'b000110,"hold4_3");
        add(1,100,110,112,5,0,6'b101111,"timeout_after_flush");
        add(0,100,110,112,5,1,6'b000000,"flush_in_cool_novalid");
        add(1,110,100, 99,5,0,6'b100101,"entry_after_cool_flush");
        add(1,110,100,100,5,1,6'b000100,"flush_long");

        #3;
        check("reset_state", outs(), 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) step(vecs[i]);

        // Async reset mid-cycle while LONG: outputs drop without a clock edge.
        begin
            vec_t x;
            x.v = 1; x.s = 8'd110; x.l = 8'd100; x.c = 8'd99; x.t = 8'd5; x.f = 0;
            x.exp = 6'b100101; x.name = "entry_before_rst";
            step(x);
            #2;
            data_valid_pre = 1'b1;
            rst = 1'b1;
            #1;
            check("async_rst_immediate", outs(), 6'b000000);
            @(posedge clk);
            #1;
            check("rst_held_over_edge", outs(), 6'b000000);
            @(negedge clk);
            rst = 1'b0;
            x.name = "entry_after_rst";
            step(x);
            x.c = 8'd100; x.exp = 6'b000101; x.name = "hold_after_rst";
            step(x);
        end

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trade_mean_fsm.md
Name: trade_mean_fsm

Overview:
Stateful mean-reversion strategy unit, the parametrised successor to the single-cycle mean-reversion comparator. It sits between the SMA pre-processing stage and the TLU. It consumes short/long SMA plus the current price each valid sample, and tracks a position (FLAT/LONG/SHORT). It issues one-cycle entry and exit order pulses, with a runtime threshold, an overflow-safe midpoint, a maximum-hold timeout and a post-exit cooldown.

Parameters:
DATA_WIDTH, 8, width of price/SMA/threshold operands
MAX_HOLD, 16, max valid samples held after entry before forced exit (>=1)
COOLDOWN, 4, valid samples ignored after any exit (0 = none)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
data_valid_pre  in  1  sample qualifier from SMA stage
short_sma  in  DATA_WIDTH  short moving average
long_sma  in  DATA_WIDTH  long moving average
current_data  in  DATA_WIDTH  current price
threshold  in  DATA_WIDTH  runtime band half-width, sampled with each valid sample
flush  in  1  synchronous force-to-FLAT
buy_signal  out  1  registered buy pulse
sell_signal  out  1  registered sell pulse
timeout_exit  out  1  pulse: current exit caused by MAX_HOLD
data_valid_mean  out  1  registered copy of data_valid_pre
position  out  2  00 FLAT, 01 LONG, 10 SHORT, 11 COOLDOWN (current FSM state)

Behaviour:
- Reset: async on rst high. All outputs 0, FSM=FLAT, hold and cooldown counters 0. Reset mid-position drops the position silently with no exit pulse.
- Arithmetic: mid = (short_sma + long_sma) >> 1, computed in DATA_WIDTH+1 bits, so there is no wrap. upper = min(mid + threshold, 2^DATA_WIDTH-1), saturating. lower = (mid > threshold) ? mid - threshold : 0. trend = short_sma > long_sma, unsigned.
- Latency: 1 cycle. A sample at edge N produces outputs visible after edge N+1. data_valid_mean <= data_valid_pre every cycle. buy/sell/timeout_exit are high only in cycles where data_valid_mean=1, and are 0 otherwise.
- Cycles with data_valid_pre=0: FSM, counters and all pulses are held or zero. No evaluation occurs.
- FSM, evaluated only on valid samples:
  - FLAT, buy entry: trend && current_data < lower -> buy pulse, LONG, hold=0.
  - FLAT, sell entry: !trend && current_data > upper -> sell pulse, SHORT, hold=0.
  - FLAT otherwise: remain FLAT.
  - LONG: n = hold+1. If current_data >= mid, or n == MAX_HOLD -> sell pulse, exit. Otherwise hold=n.
  - SHORT: n = hold+1. If current_data <= mid, or n == MAX_HOLD -> buy pulse, exit. Otherwise hold=n.
  - Revert and timeout on the same sample: single exit pulse with timeout_exit=0. Revert takes priority.
  - Exit goes to COOLDOWN with cnt=0 if COOLDOWN>0, else directly to FLAT.
  - COOLDOWN: no pulses. Each valid sample increments cnt. On the COOLDOWN-th sample go to FLAT. Entry is first possible on the following sample.
- Exit never re-enters on the same sample; at most one of buy/sell per cycle.
- flush=1 at an edge: highest priority below rst. Forces FLAT, clears counters, no pulses that cycle. data_valid_mean still follows data_valid_pre.
- threshold changes take effect on the next valid sample. No latching between samples.
- Counter widths: $clog2(MAX_HOLD+1) and $clog2(COOLDOWN+1), minimum 1 bit.

Test Plan:
1. Assert rst asynchronously mid-cycle while LONG -> all outputs 0 immediately, position=00. After release, first qualifying sample enters normally.
2. Config DATA_WIDTH=8, thr=5, COOLDOWN=2, MAX_HOLD=4:
   - Sample short=110, long=100, cur=99 (mid 105, lower 100) -> next cycle buy=1, position=01.
   - Sample cur=106 -> sell=1, position=11.
   - Two samples cur=90 -> no pulses, then position=00.
   - Third sample cur=90 -> buy=1.
3. Timeout: short=100, long=110, cur=115 -> sell=1, SHORT. Four samples cur=112 -> 4th gives buy=1, timeout_exit=1; first three give nothing.
4. Overflow: short=240, long=250, thr=20 -> mid=245, upper saturates at 255. cur=255 -> no sell; cur=254 with thr=8 (upper 253) -> sell=1.
5. Valid gaps: qualifying entry data held with data_valid_pre=0 for 5 cycles -> no pulses, counters frozen. Raise valid -> entry pulse 1 cycle later.
6. Flush while SHORT with hold=2, concurrent with a revert sample -> no pulse, position=00, hold cleared. Next qualifying sample enters.
